// File: rtl/obc_dft_bitserial_ctrl_if.sv
// Bus between one DFT bin sequencer and its surroundings: sample-set intake, slice/partial-sum ROM loop, result output.
// master = upstream/ROM bank/downstream side, slave = the sequencer.
interface obc_dft_bitserial_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int SUM_W  = 35,
    parameter int OUT_W  = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [16*DATA_W-1:0]    in_samples;
    logic signed [SUM_W-1:0] offset;
    logic [15:0]             bit_slice;
    logic                    slice_valid;
    logic signed [SUM_W-1:0] partial_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_samples, offset, partial_sum, out_ready,
        input  in_ready, bit_slice, slice_valid, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_samples, offset, partial_sum, out_ready,
        output in_ready, bit_slice, slice_valid, out_valid, out_data
    );
endinterface

// File: rtl/obc_dft_bitserial_ctrl.sv
// OBC distributed-arithmetic DFT bin sequencer: MSB-first bit-slices out, shift-accumulate partial sums in.
// Latency: first slice one cycle after acceptance, result DATA_W+1 cycles after acceptance.
// Backpressure: result held until out_ready; a new set may be accepted on the retiring edge. OBC_ROUND_EN adds round-half-up.
module obc_dft_bitserial_ctrl #(
    parameter int DATA_W     = 16,
    parameter int SUM_W      = 35,
    parameter int FRAC_SHIFT = 21,
    parameter int OUT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    output logic                    busy,
    obc_dft_bitserial_ctrl_if.slave bus
);
    localparam int ACC_W  = SUM_W + DATA_W;
    localparam int FIN_W  = ACC_W + 2;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [16*DATA_W-1:0]    samp_q, samp_d;
    logic signed [SUM_W-1:0] off_q, off_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [OUT_W-1:0] out_dat_q, out_dat_d;

    logic                    in_rdy;
    logic                    accept;
    logic [CNT_W-1:0]        bit_idx;
    logic signed [ACC_W-1:0] ps_ext;
    logic signed [ACC_W-1:0] acc_upd;
    logic signed [FIN_W-1:0] fin_sum;
    logic signed [FIN_W-1:0] fin_shift;

    assign in_rdy  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
    assign accept  = bus.in_valid && in_rdy;
    assign bit_idx = CNT_LAST - cnt_q;

    // The MSB slice carries negative weight in two's complement, hence the negation at cnt 0.
    assign ps_ext  = {{DATA_W{bus.partial_sum[SUM_W-1]}}, bus.partial_sum};
    assign acc_upd = (cnt_q == '0) ? -ps_ext : ((acc_q <<< 1) + ps_ext);

    always_comb begin
        fin_sum = FIN_W'(acc_upd) + FIN_W'(off_q);
`ifdef OBC_ROUND_EN
        if (FRAC_SHIFT > 0) begin
            fin_sum = fin_sum + (FIN_W'(1) <<< RND_SH);
        end
`endif
        fin_shift = fin_sum >>> FRAC_SHIFT;
    end

    always_comb begin
        bus.bit_slice = '0;
        if (state_q == S_RUN) begin
            for (int k = 0; k < 16; k++) begin
                bus.bit_slice[k] = samp_q[k*DATA_W + int'(bit_idx)];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        samp_d    = samp_q;
        off_d     = off_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        samp_d  = bus.in_samples;
                        off_d   = bus.offset;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d = acc_upd;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_DONE;
                        out_vld_d = 1'b1;
                        out_dat_d = OUT_W'(fin_shift);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_vld_d = 1'b0;
                        state_d   = S_IDLE;
                        if (accept) begin
                            samp_d  = bus.in_samples;
                            off_d   = bus.offset;
                            cnt_d   = '0;
                            state_d = S_RUN;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            samp_q    <= '0;
            off_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            samp_q    <= samp_d;
            off_q     <= off_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.slice_valid = (state_q == S_RUN);
    assign bus.out_valid   = out_vld_q;
    assign bus.out_data    = out_dat_q;
    assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_obc_dft_bitserial_ctrl.sv
// Directed bench: u_dut0 runs with FRAC_SHIFT=0, u_dut1 with FRAC_SHIFT=1 for the rounding cases.
module tb_obc_dft_bitserial_ctrl;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic flush0 = 1'b0;
    logic flush1 = 1'b0;
    logic busy0, busy1;
    int   n_checks = 0;
    int   n_pass   = 0;

    obc_dft_bitserial_ctrl_if #(.DATA_W(16), .SUM_W(35), .OUT_W(32)) if0 ();
    obc_dft_bitserial_ctrl_if #(.DATA_W(16), .SUM_W(35), .OUT_W(32)) if1 ();

    obc_dft_bitserial_ctrl #(.DATA_W(16), .SUM_W(35), .FRAC_SHIFT(0), .OUT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .busy(busy0), .bus(if0)
    );
    obc_dft_bitserial_ctrl #(.DATA_W(16), .SUM_W(35), .FRAC_SHIFT(1), .OUT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .busy(busy1), .bus(if1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic accept0(input logic [255:0] s, input logic signed [34:0] off);
        if0.in_valid   = 1'b1;
        if0.in_samples = s;
        if0.offset     = off;
        step();
        if0.in_valid   = 1'b0;
    endtask

    task automatic retire0();
        if0.out_ready = 1'b1;
        step();
        if0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy0); else n_pass++;
        n_checks++; if (if0.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", if0.in_ready); else n_pass++;
        n_checks++; if (if0.slice_valid !== 1'b0 || if0.bit_slice !== 16'h0000)
            $display("FAIL reset_slice got vld=%b slice=%h exp vld=0 slice=0000", if0.slice_valid, if0.bit_slice); else n_pass++;
        n_checks++; if (if0.out_valid !== 1'b0 || if0.out_data !== 32'sd0)
            $display("FAIL reset_out got vld=%b data=%0d exp vld=0 data=0", if0.out_valid, if0.out_data); else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++; if (if0.in_ready !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL idle_after_reset got rdy=%b busy=%b exp rdy=1 busy=0", if0.in_ready, busy0); else n_pass++;
    endtask

    task automatic test_slice_order();
        logic [255:0] s;
        logic [15:0]  exp_sl;
        s = '0;
        s[15:0]    = 16'h8001;
        s[255:240] = 16'h4000;
        if0.partial_sum = '0;
        accept0(s, '0);
        for (int i = 0; i < 16; i++) begin
            exp_sl = (i == 0 || i == 15) ? 16'h0001 : ((i == 1) ? 16'h8000 : 16'h0000);
            n_checks++; if (if0.slice_valid !== 1'b1 || if0.bit_slice !== exp_sl)
                $display("FAIL slice_cnt%0d got vld=%b slice=%h exp vld=1 slice=%h", i, if0.slice_valid, if0.bit_slice, exp_sl); else n_pass++;
            step();
        end
        n_checks++; if (if0.slice_valid !== 1'b0 || if0.bit_slice !== 16'h0000)
            $display("FAIL slice_after_run got vld=%b slice=%h exp vld=0 slice=0000", if0.slice_valid, if0.bit_slice); else n_pass++;
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 32'sd0)
            $display("FAIL slice_result got vld=%b data=%0d exp vld=1 data=0", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
        n_checks++; if (if0.out_valid !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL slice_retire got vld=%b busy=%b exp vld=0 busy=0", if0.out_valid, busy0); else n_pass++;
    endtask

    task automatic test_accumulation();
        logic [255:0] s;
        s = {16{16'h1234}};
        if0.partial_sum = 35'sd1;
        accept0(s, 35'sd0);
        repeat (15) step();
        n_checks++; if (if0.out_valid !== 1'b0)
            $display("FAIL acc_latency_early got vld=%b exp vld=0", if0.out_valid); else n_pass++;
        step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== -32'sd1)
            $display("FAIL acc_ones_off0 got vld=%b data=%0d exp vld=1 data=-1", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
        accept0(s, 35'sd5);
        repeat (16) step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 32'sd4)
            $display("FAIL acc_ones_off5 got vld=%b data=%0d exp vld=1 data=4", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
        // 3 on the MSB slice, 7 on the LSB slice: -3*2^15 + 7 + 100
        accept0(s, 35'sd100);
        for (int i = 0; i < 16; i++) begin
            if0.partial_sum = (i == 0) ? 35'sd3 : ((i == 15) ? 35'sd7 : 35'sd0);
            step();
        end
        if0.partial_sum = 35'sd999;
        step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== -32'sd98197)
            $display("FAIL acc_weighted got vld=%b data=%0d exp vld=1 data=-98197", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
    endtask

    task automatic test_back_to_back();
        logic [255:0] s;
        s = {16{16'hA5A5}};
        if0.partial_sum = 35'sd1;
        accept0(s, 35'sd0);
        repeat (16) step();
        if0.in_valid   = 1'b1;
        if0.in_samples = s;
        if0.offset     = 35'sd5;
        if0.out_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== -32'sd1 || if0.in_ready !== 1'b0 || if0.slice_valid !== 1'b0)
                $display("FAIL stall_%0d got vld=%b data=%0d rdy=%b svld=%b exp vld=1 data=-1 rdy=0 svld=0",
                         i, if0.out_valid, if0.out_data, if0.in_ready, if0.slice_valid); else n_pass++;
            step();
        end
        if0.out_ready = 1'b1;
        #1;
        n_checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b1)
            $display("FAIL chain_handshake got rdy=%b vld=%b exp rdy=1 vld=1", if0.in_ready, if0.out_valid); else n_pass++;
        step();
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b0;
        n_checks++; if (if0.slice_valid !== 1'b1 || if0.out_valid !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL chain_no_gap got svld=%b vld=%b busy=%b exp svld=1 vld=0 busy=1", if0.slice_valid, if0.out_valid, busy0); else n_pass++;
        repeat (16) step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 32'sd4)
            $display("FAIL chain_result got vld=%b data=%0d exp vld=1 data=4", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
    endtask

    task automatic test_flush();
        logic [255:0] s;
        logic         ov_seen;
        s = {16{16'h0F0F}};
        if0.partial_sum = 35'sd1;
        accept0(s, 35'sd0);
        repeat (7) step();
        flush0 = 1'b1;
        step();
        n_checks++; if (busy0 !== 1'b0 || if0.slice_valid !== 1'b0 || if0.out_valid !== 1'b0)
            $display("FAIL flush_idle got busy=%b svld=%b vld=%b exp busy=0 svld=0 vld=0", busy0, if0.slice_valid, if0.out_valid); else n_pass++;
        if0.in_valid   = 1'b1;
        if0.in_samples = s;
        if0.offset     = 35'sd5;
        #1;
        n_checks++; if (if0.in_ready !== 1'b0)
            $display("FAIL flush_blocks_ready got rdy=%b exp rdy=0", if0.in_ready); else n_pass++;
        step();
        n_checks++; if (busy0 !== 1'b0)
            $display("FAIL flush_no_accept got busy=%b exp busy=0", busy0); else n_pass++;
        flush0 = 1'b0;
        step();
        if0.in_valid = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ov_seen = ov_seen | if0.out_valid;
            step();
        end
        n_checks++; if (ov_seen !== 1'b0)
            $display("FAIL flush_no_output got seen=%b exp seen=0", ov_seen); else n_pass++;
        step();
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_data !== 32'sd4)
            $display("FAIL flush_recover got vld=%b data=%0d exp vld=1 data=4", if0.out_valid, if0.out_data); else n_pass++;
        retire0();
    endtask

    task automatic test_reset_mid_run();
        if0.partial_sum = 35'sd1;
        accept0({256{1'b1}}, 35'sd5);
        repeat (5) step();
        n_checks++; if (busy0 !== 1'b1 || if0.bit_slice !== 16'hFFFF)
            $display("FAIL pre_reset_run got busy=%b slice=%h exp busy=1 slice=ffff", busy0, if0.bit_slice); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b0 || if0.in_ready !== 1'b1 || if0.slice_valid !== 1'b0 || if0.bit_slice !== 16'h0000)
            $display("FAIL midrun_reset_ctrl got busy=%b rdy=%b svld=%b slice=%h exp busy=0 rdy=1 svld=0 slice=0000",
                     busy0, if0.in_ready, if0.slice_valid, if0.bit_slice); else n_pass++;
        n_checks++; if (if0.out_valid !== 1'b0 || if0.out_data !== 32'sd0)
            $display("FAIL midrun_reset_out got vld=%b data=%0d exp vld=0 data=0", if0.out_valid, if0.out_data); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (busy0 !== 1'b0 || if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0)
            $display("FAIL after_midrun_reset got busy=%b rdy=%b vld=%b exp busy=0 rdy=1 vld=0", busy0, if0.in_ready, if0.out_valid); else n_pass++;
    endtask

    task automatic test_rounding();
        logic signed [31:0] exp_p, exp_n;
`ifdef OBC_ROUND_EN
        exp_p = 32'sd2;
        exp_n = -32'sd1;
`else
        exp_p = 32'sd1;
        exp_n = -32'sd2;
`endif
        // acc_final = -1 with partial_sum held at 1; offsets 4 and -2 give pre-shift +3 and -3
        if1.partial_sum = 35'sd1;
        if1.in_samples  = '0;
        if1.in_valid    = 1'b1;
        if1.offset      = 35'sd4;
        step();
        if1.in_valid = 1'b0;
        repeat (16) step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_data !== exp_p)
            $display("FAIL round_pos got vld=%b data=%0d exp vld=1 data=%0d", if1.out_valid, if1.out_data, exp_p); else n_pass++;
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.offset    = -35'sd2;
        step();
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b0;
        repeat (16) step();
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_data !== exp_n)
            $display("FAIL round_neg got vld=%b data=%0d exp vld=1 data=%0d", if1.out_valid, if1.out_data, exp_n); else n_pass++;
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        n_checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL round_retire got vld=%b busy=%b exp vld=0 busy=0", if1.out_valid, busy1); else n_pass++;
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_samples = '0; if0.offset = '0; if0.partial_sum = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_samples = '0; if1.offset = '0; if1.partial_sum = '0; if1.out_ready = 1'b0;
        test_reset();
        test_slice_order();
        test_accumulation();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_rounding();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
